// File: rtl/lstm_elementwise_engine_if.sv
// lstm_elementwise_engine_if
//   Bundles the control, source-buffer read and state-buffer write signals
//   of the LSTM element-wise engine.
//   slave  : engine side (takes start/operands, drives reads/writes/status)
//   master : controller/buffer side
//   Signals: start, zero_cprev, rd_en, rd_addr, i/f/g/o/cprev_data,
//            wr_en, wr_addr, wr_lane_mask, ct_data, ht_data, busy, done.
interface lstm_elementwise_engine_if #(
  parameter int DATA_WIDTH   = 12,
  parameter int LANES        = 4,
  parameter int ADDRESS_BITS = 12
);
  logic                          start;
  logic                          zero_cprev;
  logic                          rd_en;
  logic [ADDRESS_BITS-1:0]       rd_addr;
  logic [LANES*DATA_WIDTH-1:0]   i_data;
  logic [LANES*DATA_WIDTH-1:0]   f_data;
  logic [LANES*DATA_WIDTH-1:0]   g_data;
  logic [LANES*DATA_WIDTH-1:0]   o_data;
  logic [LANES*DATA_WIDTH-1:0]   cprev_data;
  logic                          wr_en;
  logic [ADDRESS_BITS-1:0]       wr_addr;
  logic [LANES-1:0]              wr_lane_mask;
  logic [LANES*DATA_WIDTH-1:0]   ct_data;
  logic [LANES*DATA_WIDTH-1:0]   ht_data;
  logic                          busy;
  logic                          done;

  modport slave (
    input  start, zero_cprev, i_data, f_data, g_data, o_data, cprev_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_lane_mask, ct_data, ht_data,
           busy, done
  );

  modport master (
    output start, zero_cprev, i_data, f_data, g_data, o_data, cprev_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_lane_mask, ct_data, ht_data,
           busy, done
  );
endinterface

// File: rtl/lstm_elementwise_engine.sv
// lstm_elementwise_engine
//   Multi-lane LSTM cell update. On start, reads BEATS words of i/f/g/o and
//   C(t-1) (LANES elements per word), computes per lane
//     C(t) = sat(f*C(t-1) + i*g),  h(t) = sat(o*tanh(C(t)))
//   and writes C(t)/h(t) words back with a tail-lane mask.
//   Ports: clk, rst (sync, active low), bus (slave modport of
//   lstm_elementwise_engine_if).
//   Timing: read issued at edge t -> operands captured t+1 -> C(t) at t+2
//   -> write strobe at t+3; done one cycle after the last write.
module lstm_elementwise_engine #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAC_BITS    = 8,
  parameter int LANES        = 4,
  parameter int HIDDEN_SIZE  = 64,
  parameter int ADDRESS_BITS = 12,
  parameter int TANH_MODE    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  lstm_elementwise_engine_if.slave  bus
);

  localparam int          W     = LANES * DATA_WIDTH;
  localparam int          BEATS = (HIDDEN_SIZE + LANES - 1) / LANES;
  localparam int unsigned TAIL  = HIDDEN_SIZE - (BEATS - 1) * LANES;
  localparam logic [ADDRESS_BITS-1:0] LAST_BEAT = ADDRESS_BITS'(BEATS - 1);

  // Internal arithmetic width: covers a full DWxDW product plus a carry.
  localparam int PW = 2 * DATA_WIDTH + 1;
  typedef logic signed [PW-1:0] wide_t;

  localparam wide_t ONE_W     = wide_t'(1);
  localparam wide_t MAXV      = (ONE_W <<< (DATA_WIDTH - 1)) - ONE_W;
  localparam wide_t MINV      = -(ONE_W <<< (DATA_WIDTH - 1));
  localparam wide_t ONE       = ONE_W <<< FRAC_BITS;
  localparam wide_t HALF      = ONE >>> 1;
  localparam wide_t FIVE_HALF = (HALF <<< 2) + HALF;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state, state_n;
  logic [ADDRESS_BITS-1:0] beat;
  logic                    zc_q;

  logic                    s1_v, s2_v, s3_v;
  logic [ADDRESS_BITS-1:0] s1_addr, s2_addr, s3_addr;
  logic [W-1:0]            op_i, op_f, op_g, op_o, op_cp;
  logic [W-1:0]            s3_c, s3_o;
  logic [W-1:0]            c_next, h_next;
  logic [LANES-1:0]        mask_next;

  // Fixed-point product, arithmetic shift right (floor).
  function automatic wide_t mulsh(input wide_t a, input wide_t b);
    return (a * b) >>> FRAC_BITS;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sat(input wide_t v);
    if (v > MAXV)      return MAXV[DATA_WIDTH-1:0];
    else if (v < MINV) return MINV[DATA_WIDTH-1:0];
    else               return v[DATA_WIDTH-1:0];
  endfunction

  function automatic wide_t tanh_f(input wide_t c);
    wide_t x, y;
    x = (c < 0) ? -c : c;
    if (TANH_MODE == 0)      y = (x > ONE) ? ONE : x;
    else if (x < HALF)       y = x;
    else if (x < FIVE_HALF)  y = HALF + ((x - HALF) >>> 2);
    else                     y = ONE;
    return (c < 0) ? -y : y;
  endfunction

  function automatic wide_t lane(input logic [W-1:0] word, input int unsigned k);
    return wide_t'($signed(word[k*DATA_WIDTH +: DATA_WIDTH]));
  endfunction

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    bus.rd_en  = 1'b0;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_n = ISSUE;
      end
      ISSUE: begin
        bus.rd_en = 1'b1;
        if (beat == LAST_BEAT) state_n = DRAIN;
      end
      DRAIN: begin
        if (bus.wr_en && bus.wr_addr == LAST_BEAT) state_n = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.rd_addr = beat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat <= '0;
      zc_q <= 1'b0;
    end else begin
      if (state == ISSUE) beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      if (state == IDLE && bus.start) zc_q <= bus.zero_cprev;
    end
  end

  // ---------------- datapath ----------------
  always_comb begin
    c_next    = '0;
    h_next    = '0;
    mask_next = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      c_next[k*DATA_WIDTH +: DATA_WIDTH] =
        sat((zc_q ? wide_t'(0) : mulsh(lane(op_f, k), lane(op_cp, k)))
            + mulsh(lane(op_i, k), lane(op_g, k)));
      h_next[k*DATA_WIDTH +: DATA_WIDTH] =
        sat(mulsh(lane(s3_o, k), tanh_f(lane(s3_c, k))));
      mask_next[k] = (s3_addr != LAST_BEAT) || (k < TAIL);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v             <= 1'b0;
      s2_v             <= 1'b0;
      s3_v             <= 1'b0;
      s1_addr          <= '0;
      s2_addr          <= '0;
      s3_addr          <= '0;
      op_i             <= '0;
      op_f             <= '0;
      op_g             <= '0;
      op_o             <= '0;
      op_cp            <= '0;
      s3_c             <= '0;
      s3_o             <= '0;
      bus.wr_en        <= 1'b0;
      bus.wr_addr      <= '0;
      bus.wr_lane_mask <= '0;
      bus.ct_data      <= '0;
      bus.ht_data      <= '0;
    end else begin
      s1_v    <= bus.rd_en;
      s1_addr <= bus.rd_addr;
      s2_v    <= s1_v;
      s2_addr <= s1_addr;
      if (s1_v) begin
        op_i  <= bus.i_data;
        op_f  <= bus.f_data;
        op_g  <= bus.g_data;
        op_o  <= bus.o_data;
        op_cp <= bus.cprev_data;
      end
      s3_v    <= s2_v;
      s3_addr <= s2_addr;
      if (s2_v) begin
        s3_c <= c_next;
        s3_o <= op_o;
      end
      bus.wr_en <= s3_v;
      if (s3_v) begin
        bus.wr_addr      <= s3_addr;
        bus.wr_lane_mask <= mask_next;
        bus.ct_data      <= s3_c;
        bus.ht_data      <= h_next;
      end
    end
  end

endmodule

// File: tb/tb_lstm_elementwise_engine.sv
module tb_lstm_elementwise_engine;
  localparam int DW = 12;
  localparam int L  = 4;
  localparam int AB = 12;
  localparam int HS = 10;
  localparam int NB = 3;
  localparam int NE = NB * L;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lstm_elementwise_engine_if #(.DATA_WIDTH(DW), .LANES(L), .ADDRESS_BITS(AB)) bus0();
  lstm_elementwise_engine_if #(.DATA_WIDTH(DW), .LANES(L), .ADDRESS_BITS(AB)) bus1();

  lstm_elementwise_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(L), .HIDDEN_SIZE(HS),
                            .ADDRESS_BITS(AB), .TANH_MODE(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

  lstm_elementwise_engine #(.DATA_WIDTH(DW), .FRAC_BITS(8), .LANES(L), .HIDDEN_SIZE(HS),
                            .ADDRESS_BITS(AB), .TANH_MODE(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Vector: operands, then expected ct/h(mode0)/h(mode1) with C(t-1) used,
  // then the same three with zero_cprev.
  typedef struct {
    int i, f, g, o, cp;
    int ct, h0, h1;
    int ctz, hz0, hz1;
  } vec_t;

  typedef struct {
    logic [AB-1:0]   addr;
    int              cyc;
    logic [L-1:0]    mask;
    logic [L*DW-1:0] ct;
    logic [L*DW-1:0] ht;
  } exp_t;

  vec_t vt[8];
  exp_t q0[$];
  exp_t q1[$];
  logic [L*DW-1:0] mem_i[NB], mem_f[NB], mem_g[NB], mem_o[NB], mem_cp[NB];
  int sel[NE];
  bit zc_run;
  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;
  int rd_cnt0  = 0;
  int rd_cnt1  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (bus0.rd_en && int'(bus0.rd_addr) < NB) begin
      bus0.i_data     <= mem_i[int'(bus0.rd_addr)];
      bus0.f_data     <= mem_f[int'(bus0.rd_addr)];
      bus0.g_data     <= mem_g[int'(bus0.rd_addr)];
      bus0.o_data     <= mem_o[int'(bus0.rd_addr)];
      bus0.cprev_data <= mem_cp[int'(bus0.rd_addr)];
    end
    if (bus1.rd_en && int'(bus1.rd_addr) < NB) begin
      bus1.i_data     <= mem_i[int'(bus1.rd_addr)];
      bus1.f_data     <= mem_f[int'(bus1.rd_addr)];
      bus1.g_data     <= mem_g[int'(bus1.rd_addr)];
      bus1.o_data     <= mem_o[int'(bus1.rd_addr)];
      bus1.cprev_data <= mem_cp[int'(bus1.rd_addr)];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  function automatic exp_t make_exp(input int d, input logic [AB-1:0] addr);
    exp_t e;
    vec_t v;
    int n;
    e.addr = addr;
    e.cyc  = cyc + 1;
    e.mask = '0;
    e.ct   = '0;
    e.ht   = '0;
    for (int k = 0; k < L; k++) begin
      n = int'(addr) * L + k;
      if (n < NE) begin
        v = vt[sel[n]];
        e.mask[k] = (n < HS);
        e.ct[k*DW +: DW] = DW'(zc_run ? v.ctz : v.ct);
        if (d == 0) e.ht[k*DW +: DW] = DW'(zc_run ? v.hz0 : v.h0);
        else        e.ht[k*DW +: DW] = DW'(zc_run ? v.hz1 : v.h1);
      end
    end
    return e;
  endfunction

  task automatic observe(input int d, input logic rd_en, input logic [AB-1:0] rd_addr,
                         input logic wr_en, input logic [AB-1:0] wr_addr,
                         input logic [L-1:0] mask, input logic [L*DW-1:0] ct,
                         input logic [L*DW-1:0] ht, input logic busy);
    exp_t e;
    string tag;
    bit have;
    tag = (d == 0) ? "m0" : "m1";
    if (wr_en) begin
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        total++;
        $display("FAIL %s_unexpected_write: got wr_addr %0d required no write", tag, wr_addr);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(e.addr));
        chk({tag, "_wr_latency"}, 64'(cyc - e.cyc), 64'(3));
        chk({tag, "_mask"}, 64'(mask), 64'(e.mask));
        chk({tag, "_ct"}, 64'(ct), 64'(e.ct));
        chk({tag, "_ht"}, 64'(ht), 64'(e.ht));
      end
    end
    if (rd_en) begin
      if (d == 0) begin
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(rd_cnt0));
        rd_cnt0++;
        q0.push_back(make_exp(d, rd_addr));
      end else begin
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(rd_cnt1));
        rd_cnt1++;
        q1.push_back(make_exp(d, rd_addr));
      end
    end
    if (!busy) begin
      if (d == 0) rd_cnt0 = 0;
      else        rd_cnt1 = 0;
    end
  endtask

  always @(negedge clk) begin
    observe(0, bus0.rd_en, bus0.rd_addr, bus0.wr_en, bus0.wr_addr, bus0.wr_lane_mask,
            bus0.ct_data, bus0.ht_data, bus0.busy);
    observe(1, bus1.rd_en, bus1.rd_addr, bus1.wr_en, bus1.wr_addr, bus1.wr_lane_mask,
            bus1.ct_data, bus1.ht_data, bus1.busy);
    if (!rst) begin
      q0.delete();
      q1.delete();
    end
  end

  task automatic fill(input int offs);
    vec_t v;
    for (int n = 0; n < NE; n++) begin
      sel[n] = (n + offs) % 8;
      v = vt[sel[n]];
      mem_i[n/L][(n%L)*DW +: DW]  = DW'(v.i);
      mem_f[n/L][(n%L)*DW +: DW]  = DW'(v.f);
      mem_g[n/L][(n%L)*DW +: DW]  = DW'(v.g);
      mem_o[n/L][(n%L)*DW +: DW]  = DW'(v.o);
      mem_cp[n/L][(n%L)*DW +: DW] = DW'(v.cp);
    end
  endtask

  task automatic drive_start(input logic s, input logic zc);
    bus0.start = s;  bus1.start = s;
    bus0.zero_cprev = zc;  bus1.zero_cprev = zc;
  endtask

  task automatic run(input int offs, input bit zc, input bit poke);
    int sc;
    bit seen;
    fill(offs);
    zc_run = zc;
    @(negedge clk);
    drive_start(1'b1, zc);
    sc = cyc + 1;
    @(negedge clk);
    drive_start(1'b0, 1'b0);
    chk("busy_after_start", 64'({bus0.busy, bus1.busy}), 64'(2'b11));
    seen = 0;
    for (int w = 0; w < 40 && !seen; w++) begin
      if (poke && w == 2) drive_start(1'b1, ~zc);
      else                drive_start(1'b0, 1'b0);
      @(negedge clk);
      if (bus0.done) begin
        seen = 1;
        chk("done_latency", 64'(cyc - sc), 64'(NB + 4));
        chk("done_both_busy", 64'({bus1.done, bus0.busy, bus1.busy}), 64'(3'b111));
        chk("queues_drained", 64'(q0.size() + q1.size()), 64'(0));
      end
    end
    drive_start(1'b0, 1'b0);
    if (!seen) begin
      total++;
      $display("FAIL done_timeout: got no done within 40 cycles required done");
      return;
    end
    if (poke) drive_start(1'b1, 1'b0);
    @(negedge clk);
    drive_start(1'b0, 1'b0);
    chk("idle_after_done", 64'({bus0.busy, bus0.done, bus1.busy, bus1.done}), 64'(0));
  endtask

  initial begin
    vt[0] = '{256, 256, 128, 256, 128,    256,  256,  160,    128,  128,  128};
    vt[1] = '{0, 1792, 0, 256, 1792,      2047, 256,  256,    0,    0,    0};
    vt[2] = '{-2048, 0, 2047, 256, 0,     -2048, -256, -256,  -2048, -256, -256};
    vt[3] = '{256, 256, 64, 256, 1000,    1064, 256,  256,    64,   64,   64};
    vt[4] = '{200, 100, -300, -128, 300,  -118, 59,   59,     -235, 117,  77};
    vt[5] = '{256, 128, 300, 200, -100,   250,  195,  123,    300,  200,  133};
    vt[6] = '{-256, 0, 100, 3, 0,         -100, -2,   -2,     -100, -2,   -2};
    vt[7] = '{256, 0, 639, 256, 5,        639,  256,  255,    639,  256,  255};
    fill(0);
    zc_run = 0;
    drive_start(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_ctrl0", 64'({bus0.rd_en, bus0.wr_en, bus0.busy, bus0.done}), 64'(0));
    chk("rst_ctrl1", 64'({bus1.rd_en, bus1.wr_en, bus1.busy, bus1.done}), 64'(0));
    chk("rst_addr", 64'({bus0.rd_addr, bus0.wr_addr, bus0.wr_lane_mask}), 64'(0));
    chk("rst_ct", 64'(bus0.ct_data), 64'(0));
    chk("rst_ht", 64'(bus0.ht_data), 64'(0));
    rst = 1'b1;

    run(0, 1'b0, 1'b0);
    run(3, 1'b1, 1'b1);

    // Reset after the second write of a run.
    begin
      int nw;
      fill(1);
      zc_run = 0;
      @(negedge clk);
      drive_start(1'b1, 1'b0);
      @(negedge clk);
      drive_start(1'b0, 1'b0);
      nw = 0;
      for (int w = 0; w < 20 && nw < 2; w++) begin
        @(negedge clk);
        if (bus0.wr_en) nw++;
      end
      if (nw < 2) begin
        total++;
        $display("FAIL midrun_writes: got %0d writes required 2", nw);
      end
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
        if (c == 2) rst = 1'b1;
        @(negedge clk);
        chk("after_reset_quiet",
            64'({bus0.wr_en, bus0.busy, bus0.done, bus1.wr_en, bus1.busy, bus1.done}),
            64'(0));
      end
    end

    run(5, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
